// File: rtl/led_view_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_view_pkg
// Shared types and helpers for the LED view sequencer.
//   view_t     : the three legal view-select codes driven to the LED mux
//   next_view  : DATA0 -> NIBBLE -> FULL -> DATA0 advance order
//   to_view    : maps a raw 2-bit code onto a legal view (11 folds to DATA0)
// ----------------------------------------------------------------------------
package led_view_pkg;

    typedef enum logic [1:0] {
        VIEW_DATA0  = 2'b00,
        VIEW_NIBBLE = 2'b01,
        VIEW_FULL   = 2'b10
    } view_t;

    // Step to the following view, wrapping from FULL back to DATA0.
    function automatic view_t next_view(input view_t v);
        case (v)
            VIEW_DATA0:  next_view = VIEW_NIBBLE;
            VIEW_NIBBLE: next_view = VIEW_FULL;
            default:     next_view = VIEW_DATA0;
        endcase
    endfunction

    // The unused code 11 has no view behind it, so it falls back to DATA0
    // rather than ever being driven onto the mux select.
    function automatic view_t to_view(input logic [1:0] code);
        case (code)
            2'b01:   to_view = VIEW_NIBBLE;
            2'b10:   to_view = VIEW_FULL;
            default: to_view = VIEW_DATA0;
        endcase
    endfunction

endpackage

// File: rtl/led_view_ctrl_btn_debouncer.sv
// ----------------------------------------------------------------------------
// btn_debouncer
// Synchronizes a raw pushbutton, filters contact bounce and emits a
// single-cycle pulse on each accepted rising edge.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   btn_in  in   raw asynchronous button level
//   level   out  debounced button level
//   press   out  one-cycle pulse when the debounced level rises
// ----------------------------------------------------------------------------
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window, so a
    // glitch shorter than the window never reaches the terminal count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizer, debounce state and a delayed copy of the
    // level used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_q        <= btn_in;
            s2_q        <= s1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    // Only the press edge advances the view; release is ignored.
    assign press = level_q & ~level_dly_q;
    assign level = level_q;

endmodule

// File: rtl/led_view_ctrl.sv
// ----------------------------------------------------------------------------
// led_view_ctrl
// Sequencer for the 2-bit view select of the 16-LED output mux. Views cycle
// DATA0 -> NIBBLE -> FULL from a direct switch load, a debounced "next"
// button, or an auto-rotate dwell timer, in that priority; hold freezes it.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   btn_next      in   raw pushbutton, active-high
//   auto_en       in   enable auto-rotate
//   hold          in   freeze current view, discard advance sources
//   load          in   single-cycle strobe to load view from load_view
//   load_view     in   requested view code (11 treated as 00)
//   sel           out  view select: 00 data0, 01 nibble, 10 full
//   view_changed  out  one-cycle pulse when a new sel value first appears
// ----------------------------------------------------------------------------
module led_view_ctrl
    import led_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_PERIOD     = 200_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       hold,
    input  logic       load,
    input  logic [1:0] load_view,
    output logic [1:0] sel,
    output logic       view_changed
);

    localparam int DW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_PERIOD - 1);

    view_t         view_q;
    view_t         view_d;
    view_t         load_target;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic          changed_q;
    logic          changed_d;
    logic          btn_press;
    logic          btn_level;
    logic          auto_tick;
    logic          unused_btn_level;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_next),
        .level  (btn_level),
        .press  (btn_press)
    );

    // The debounced level is exported by the debouncer for board-level
    // indication; the sequencer itself only reacts to the press pulse.
    assign unused_btn_level = btn_level;

    assign load_target = to_view(load_view);
    assign auto_tick   = auto_en && (dwell_q == DWELL_LAST);

    // hold wins outright and leaves the dwell count frozen, so a tick that
    // was due resumes as soon as hold drops. A press coinciding with a tick
    // shares one advance because both feed the same branch.
    always_comb begin
        view_d    = view_q;
        dwell_d   = dwell_q;
        changed_d = 1'b0;
        if (!hold) begin
            if (load) begin
                view_d    = load_target;
                dwell_d   = '0;
                changed_d = (load_target != view_q);
            end else if (btn_press || auto_tick) begin
                view_d    = next_view(view_q);
                dwell_d   = '0;
                changed_d = 1'b1;
            end else if (auto_en) begin
                dwell_d = dwell_q + 1'b1;
            end else begin
                dwell_d = '0;
            end
        end
    end

    // view_changed is registered alongside the view so it lines up with
    // the first cycle the new select is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            view_q    <= VIEW_DATA0;
            dwell_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            view_q    <= view_d;
            dwell_q   <= dwell_d;
            changed_q <= changed_d;
        end
    end

    assign sel          = view_q;
    assign view_changed = changed_q;

endmodule

// File: tb/tb_led_view_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_view_ctrl
// Self-checking bench for led_view_ctrl with a short debounce window and
// dwell period. A behavioural model tracks the expected select and pulse.
// ----------------------------------------------------------------------------
module tb_led_view_ctrl;

    localparam int DEB  = 4;
    localparam int AUTO = 8;

    logic       clk;
    logic       reset;
    logic       btn_next;
    logic       auto_en;
    logic       hold;
    logic       load;
    logic [1:0] load_view;
    logic [1:0] sel;
    logic       view_changed;

    int testsRun;
    int testsFailed;

    // Behavioural model state
    bit mSync1;
    bit mSync2;
    bit mLevel;
    bit mLevelPrev;
    int mRun;
    int mSel;
    int mDwell;
    bit mChanged;

    led_view_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD    (AUTO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .auto_en      (auto_en),
        .hold         (hold),
        .load         (load),
        .load_view    (load_view),
        .sel          (sel),
        .view_changed (view_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance the model by one clock edge using the inputs seen at that edge.
    // The button is accepted once its synchronized value has disagreed with
    // the accepted level for DEB consecutive samples.
    task automatic modelStep();
        bit pressNow;
        int nv;
        if (reset) begin
            mSync1 = 0; mSync2 = 0; mLevel = 0; mLevelPrev = 0;
            mRun = 0; mSel = 0; mDwell = 0; mChanged = 0;
        end else begin
            pressNow = mLevel && !mLevelPrev;
            mChanged = 0;
            if (!hold) begin
                if (load) begin
                    nv = (load_view == 2'b11) ? 0 : int'(load_view);
                    mChanged = (nv != mSel);
                    mSel = nv;
                    mDwell = 0;
                end else if (pressNow || (auto_en && mDwell == AUTO - 1)) begin
                    mSel = (mSel + 1) % 3;
                    mChanged = 1;
                    mDwell = 0;
                end else begin
                    mDwell = auto_en ? mDwell + 1 : 0;
                end
            end
            mLevelPrev = mLevel;
            if (mSync2 != mLevel) begin
                mRun++;
                if (mRun == DEB) begin
                    mLevel = mSync2;
                    mRun = 0;
                end
            end else begin
                mRun = 0;
            end
            mSync2 = mSync1;
            mSync1 = btn_next;
        end
    endtask

    // One clock edge: update the model at the edge, then settle 1 time unit
    // so the caller samples outputs and drives new inputs away from the edge.
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; btn_next = 1'b0; auto_en = 1'b0;
        hold = 1'b0; load = 1'b0; load_view = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_next = 1'b1; auto_en = 1'b1;
        hold = 1'b0; load = 1'b1; load_view = 2'b10;
        tick();
        testsRun++;
        if (sel !== 2'b00 || view_changed !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: sel=%0d vc=%0d expected sel=0 vc=0", sel, view_changed);
        end
        reset = 1'b0; btn_next = 1'b0; auto_en = 1'b0; load = 1'b0;
    endtask

    task automatic test_press_held();
        int expSel;
        bit expVc;
        doReset();
        btn_next = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            expSel = (k >= DEB + 3) ? 1 : 0;
            expVc  = (k == DEB + 3);
            testsRun++;
            if (sel !== expSel[1:0] || view_changed !== expVc
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL press_held edge %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         k, sel, view_changed, expSel, expVc);
            end
        end
        btn_next = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            testsRun++;
            if (sel !== 2'b01 || view_changed !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL press_release cycle %0d: sel=%0d vc=%0d expected sel=1 vc=0",
                         k, sel, view_changed);
            end
        end
    endtask

    task automatic test_glitch();
        doReset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) begin
                btn_next = (r < 3 && c < 3) ? 1'b1 : 1'b0;
                tick();
                testsRun++;
                if (sel !== 2'b00 || view_changed !== 1'b0
                    || sel !== mSel[1:0] || view_changed !== mChanged) begin
                    testsFailed++;
                    $display("[TB] FAIL glitch r%0d c%0d: sel=%0d vc=%0d expected sel=0 vc=0",
                             r, c, sel, view_changed);
                end
            end
        end
    endtask

    task automatic test_auto_rotate();
        int expSel;
        bit expVc;
        doReset();
        auto_en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            expSel = (k / AUTO) % 3;
            expVc  = (k % AUTO == 0);
            testsRun++;
            if (sel !== expSel[1:0] || view_changed !== expVc
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL auto_rotate edge %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         k, sel, view_changed, expSel, expVc);
            end
        end
        auto_en = 1'b0;
    endtask

    // Button raised one cycle after auto_en so its press lands on the
    // first dwell tick; both must collapse into a single advance.
    task automatic test_press_on_tick();
        int expSel;
        bit expVc;
        doReset();
        auto_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) btn_next = 1'b1;
            expSel = (k >= 2 * AUTO) ? 2 : (k >= AUTO) ? 1 : 0;
            expVc  = (k == AUTO) || (k == 2 * AUTO);
            testsRun++;
            if (sel !== expSel[1:0] || view_changed !== expVc
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL press_on_tick edge %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         k, sel, view_changed, expSel, expVc);
            end
        end
        btn_next = 1'b0;
        auto_en = 1'b0;
    endtask

    task automatic test_load();
        logic [1:0] lv [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        logic [1:0] es [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
        bit         ev [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        doReset();
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; load_view = lv[i];
            tick();
            testsRun++;
            if (sel !== es[i] || view_changed !== ev[i]
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL load step %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         i, sel, view_changed, es[i], ev[i]);
            end
        end
        load = 1'b0;
        tick();
        testsRun++;
        if (sel !== 2'b01 || view_changed !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_idle: sel=%0d vc=%0d expected sel=1 vc=0", sel, view_changed);
        end

        // Load strobe on the same edge the debounced press is consumed.
        doReset();
        btn_next = 1'b1;
        for (int k = 1; k <= DEB + 2; k++) tick();
        load = 1'b1; load_view = 2'b10;
        tick();
        load = 1'b0;
        testsRun++;
        if (sel !== 2'b10 || view_changed !== 1'b1 || sel !== mSel[1:0]) begin
            testsFailed++;
            $display("[TB] FAIL load_vs_press: sel=%0d vc=%0d expected sel=2 vc=1", sel, view_changed);
        end
        tick();
        testsRun++;
        if (sel !== 2'b10 || view_changed !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_vs_press_after: sel=%0d vc=%0d expected sel=2 vc=0", sel, view_changed);
        end
        btn_next = 1'b0;
    endtask

    task automatic test_hold_and_reset();
        doReset();
        auto_en = 1'b1;
        for (int k = 1; k < AUTO; k++) tick();
        hold = 1'b1; btn_next = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            testsRun++;
            if (sel !== 2'b00 || view_changed !== 1'b0
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL hold cycle %0d: sel=%0d vc=%0d expected sel=0 vc=0",
                         k, sel, view_changed);
            end
        end
        hold = 1'b0; btn_next = 1'b0;
        tick();
        testsRun++;
        if (sel !== 2'b01 || view_changed !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL hold_release_tick: sel=%0d vc=%0d expected sel=1 vc=1", sel, view_changed);
        end

        load = 1'b1; load_view = 2'b10;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if (sel !== 2'b00 || view_changed !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_dwell_reset: sel=%0d vc=%0d expected sel=0 vc=0", sel, view_changed);
        end
        for (int k = 1; k <= AUTO; k++) begin
            tick();
            testsRun++;
            if (sel !== ((k == AUTO) ? 2'b01 : 2'b00) || view_changed !== (k == AUTO)
                || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_dwell edge %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         k, sel, view_changed, (k == AUTO) ? 1 : 0, (k == AUTO));
            end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_random();
        doReset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            hold      = ($urandom_range(0, 9) == 0);
            load      = ($urandom_range(0, 14) == 0);
            load_view = 2'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 199) == 0);
            tick();
            testsRun++;
            if (sel === 2'b11 || sel !== mSel[1:0] || view_changed !== mChanged) begin
                testsFailed++;
                $display("[TB] FAIL random cycle %0d: sel=%0d vc=%0d expected sel=%0d vc=%0d",
                         k, sel, view_changed, mSel, mChanged);
            end
        end
        reset = 1'b0; hold = 1'b0; load = 1'b0; auto_en = 1'b0; btn_next = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_press_held();
        test_glitch();
        test_auto_rotate();
        test_press_on_tick();
        test_load();
        test_hold_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
